// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide over WIDTH cycles.
// Optional `MULDIV_EARLY_OUT_EN skips the iteration for operations with a trivially known result.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned      CntW     = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastIter = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] mag_q;   // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0] hi_q;    // product high word, or partial remainder
  logic [WIDTH-1:0] lo_q;    // multiplier/product low word, or dividend/quotient
  logic [CntW-1:0]  cnt_q;
  logic             neg_q, rem_neg_q;
  logic             ready_q, busy_q, done_q;
  logic [WIDTH-1:0] result_q;

  function automatic logic trivial(input logic [2:0] f3, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    if (f3[2]) return (b == '0) || (!f3[0] && a == MinNeg && b == '1);
    return (a == '0) || (b == '0);
  endfunction

  function automatic logic [WIDTH-1:0] trivial_value(input logic [2:0] f3,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
    if (!f3[2]) return '0;
    if (b == '0) return f3[1] ? a : '1;
    return f3[1] ? '0 : a;
  endfunction

  // Operand sign decode for the incoming request
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
            (funct3 == 3'b110);
    b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg = a_sgn & op_a[WIDTH-1];
    b_neg = b_sgn & op_b[WIDTH-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
  end

  // One iteration step of either datapath
  logic [WIDTH:0]   sum, shifted;
  logic             ge;
  logic [WIDTH-1:0] hi_n, lo_n;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, mag_q};
    if (f3_q[2]) begin
      hi_n = ge ? WIDTH'(shifted - {1'b0, mag_q}) : shifted[WIDTH-1:0];
      lo_n = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction and special-case selection evaluated in FIX
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   final_val;

  always_comb begin
    prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    if (trivial(f3_q, a_q, b_q)) begin
      final_val = trivial_value(f3_q, a_q, b_q);
    end else if (!f3_q[2]) begin
      final_val = (f3_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end else if (f3_q[1]) begin
      final_val = rem_neg_q ? -hi_q : hi_q;
    end else begin
      final_val = neg_q ? -lo_q : lo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      f3_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mag_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            f3_q      <= funct3;
            a_q       <= op_a;
            b_q       <= op_b;
            mag_q     <= funct3[2] ? b_mag : a_mag;
            lo_q      <= funct3[2] ? a_mag : b_mag;
            hi_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            ready_q   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            if (trivial(funct3, op_a, op_b)) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              result_q <= trivial_value(funct3, op_a, op_b);
            end else begin
              state_q <= StCalc;
              busy_q  <= 1'b1;
            end
`else
            state_q <= StCalc;
            busy_q  <= 1'b1;
`endif
          end
        end
        StCalc: begin
          if (flush) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == LastIter) state_q <= StFix;
          end
        end
        StFix: begin
          busy_q <= 1'b0;
          if (flush) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            state_q  <= StDone;
            done_q   <= 1'b1;
            result_q <= final_val;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: vector table, result scoreboard, flush/reset corner sequences.
module tb_muldiv_sequencer;
  localparam int unsigned WIDTH = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  localparam logic [2:0] OpMul = 3'b000, OpMulh = 3'b001, OpMulhsu = 3'b010, OpMulhu = 3'b011;
  localparam logic [2:0] OpDiv = 3'b100, OpDivu = 3'b101, OpRem = 3'b110, OpRemu = 3'b111;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        ready, busy, done;
  logic [31:0] result;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          triv;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  string       cur_name = "none";
  int          checks = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic add(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit triv);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.triv = triv;
    vecs.push_back(v);
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation
  initial forever begin
    @(posedge clk); #1;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", {31'b0, done}, 32'd0);
      else check(cur_name, result, exp_q.pop_front());
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit with_flush);
    int n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_start", {31'b0, ready}, 32'd1);
    start = 1'b1; flush = with_flush; funct3 = f3; op_a = a; op_b = b;
    @(posedge clk); #1;
    // Scramble inputs so any failure to latch shows up in the result
    start = 1'b0; flush = 1'b0;
    funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat = 1;
    int busy_cycles = 0;
    int exp_lat, exp_busy;
    exp_lat  = (EarlyOut && v.triv) ? 1 : WIDTH + 2;
    exp_busy = (EarlyOut && v.triv) ? 0 : WIDTH + 1;
    cur_name = name;
    exp_q.push_back(v.exp);
    issue(v.f3, v.a, v.b, 1'b0);
    forever begin
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1 || lat >= 100) break;
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) exp_q.delete();
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, busy_cycles, exp_busy);
    @(posedge clk); #1;
    check({name, "_ready_after"}, {31'b0, ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] last_exp;
    bit          seen;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;

    add(OpMul,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
    add(OpMulh,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
    add(OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    add(OpMulhsu, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
    add(OpDiv,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
    add(OpRem,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    add(OpDivu,   32'd100,      32'd7,        32'd14,       1'b0);
    add(OpRemu,   32'd100,      32'd7,        32'd2,        1'b0);
    add(OpDivu,   32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1);
    add(OpRemu,   32'h1234,     32'd0,        32'h1234,     1'b1);
    add(OpDiv,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
    add(OpRem,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1);
    add(OpMul,    32'd0,        32'h12345,    32'd0,        1'b1);
    add(OpMulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b0);
    add(OpMulhu,  32'h12345678, 32'h10,       32'd1,        1'b0);
    add(OpDiv,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0);
    add(OpRem,    32'd7,        32'hFFFFFFFE, 32'd1,        1'b0);
    add(OpRem,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0);
    add(OpDiv,    32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
    add(OpRem,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1);
    add(OpMulhsu, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    add(OpDivu,   32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0);
    add(OpMul,    32'h12345,    32'h10,       32'h123450,   1'b0);
    last_exp = 32'h123450;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready",  {31'b0, ready}, 32'd1);
    check("reset_busy",   {31'b0, busy},  32'd0);
    check("reset_done",   {31'b0, done},  32'd0);
    check("reset_result", result,         32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Flush ten cycles into CALC
    issue(OpMul, 32'd9, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready",  {31'b0, ready}, 32'd1);
    check("flush_busy",   {31'b0, busy},  32'd0);
    check("flush_result", result,         last_exp);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("flush_no_done", {31'b0, seen}, 32'd0);

    // Start and flush in the same cycle: start is dropped
    issue(OpDivu, 32'd100, 32'd7, 1'b1);
    check("startflush_ready", {31'b0, ready}, 32'd1);
    check("startflush_busy",  {31'b0, busy},  32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    check("startflush_no_done", {31'b0, seen}, 32'd0);
    check("startflush_result",  result,        last_exp);

    // Asynchronous reset in the middle of CALC
    issue(OpMul, 32'd11, 32'd13, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_ready",  {31'b0, ready}, 32'd1);
    check("midreset_busy",   {31'b0, busy},  32'd0);
    check("midreset_done",   {31'b0, done},  32'd0);
    check("midreset_result", result,         32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      vec_t v;
      v.f3 = OpMul; v.a = 32'd3; v.b = 32'd5; v.exp = 32'd15; v.triv = 1'b0;
      run_op(v, "after_reset_mul");
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RISC-V M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), run beside the single-cycle ALU. The core issues an operation when Funct7 = 7'b0000001 on an R-type instruction. The block runs an iterative shift-add multiply or restoring divide over WIDTH cycles, applies sign correction, and pulses a one-cycle completion. Pipeline control stalls on `busy`.

## Interface
- WIDTH, 32, operand and result width in bits; must be at least 2.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in the cycle where `ready`=1.
- flush  input  1  abort the operation in flight; no `done` is produced.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  WIDTH  rs1 operand (multiplicand or dividend).
- op_b  input  WIDTH  rs2 operand (multiplier or divisor).
- ready  output  1  high in IDLE only.
- busy  output  1  high in CALC and FIX.
- done  output  1  one-cycle pulse; `result` is valid in this cycle.
- result  output  WIDTH  final value; held until the next accepted start.

## Operation
- States and transitions:
  - IDLE → CALC on an accepted start.
  - CALC → FIX after WIDTH iterations.
  - FIX → DONE.
  - DONE → IDLE.
- On an accepted start, latch funct3, op_a and op_b. Later changes to the inputs have no effect.
- Sign handling:
  - Signed operands are converted to magnitude at start.
  - MULH uses both operands signed. MULHSU uses op_a signed and op_b unsigned. MULHU, DIVU and REMU treat both as unsigned. MUL has the same low word either way.
- Multiply:
  - A 2·WIDTH-bit product register.
  - Each CALC cycle does one conditional add of the multiplicand, then a right shift.
  - FIX negates the product when the operand signs differ (signed cases only).
  - MUL returns the low WIDTH bits. MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per CALC cycle.
  - FIX negates the quotient when signs differ (DIV) and gives the remainder the dividend's sign (REM).
- Special cases (RISC-V defined; the result is checked at FIX):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return op_a.
  - Signed overflow (op_a = 1 followed by WIDTH-1 zeros, op_b = all ones): DIV returns op_a; REM returns 0.
- `result` is written only when entering DONE.
- Flush:
  - A flush in CALC or FIX goes to IDLE on the next edge. `result` is unchanged and there is no `done`.
  - A flush in DONE still lets `done` complete.
  - A flush in the same cycle as a start: flush wins and the start is dropped.
- start while not ready: ignored; nothing is queued.

## Timing
- Start accepted at cycle T:
  - CALC runs T+1 … T+WIDTH.
  - FIX is at T+WIDTH+1.
  - `done` and `result` are valid at T+WIDTH+2.
  - `ready` returns at T+WIDTH+3.
- Total latency is WIDTH+2 cycles (34 for the default WIDTH), with no data dependence unless the early-out feature is compiled in.
- Back-to-back throughput: one operation every WIDTH+3 cycles.
- Reset values: ready=1, busy=0, done=0, result=0, state IDLE, all internal registers 0.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). The operation is lost.

## Configuration
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - An accepted start whose result is trivially known goes IDLE → DONE directly, with `done` at T+1.
  - Trivial cases: divisor 0 (DIV/DIVU/REM/REMU), signed overflow (DIV/REM), and op_a=0 or op_b=0 (any multiply).
  - Results match the values under Operation.
- Undefined: every operation takes the full WIDTH+2 cycles. Special-case values are still correct.

## Test plan
- MUL op_a=7, op_b=0xFFFFFFFD → result 0xFFFFFFEB, `done` exactly 34 cycles after start, `busy` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV op_a=0xFFFFFFF9 (−7), op_b=2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 0x1234/0 → 0xFFFFFFFF and REMU → 0x1234. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0. Timing: 34 cycles without the macro; `done` at T+1 with MULDIV_EARLY_OUT_EN.
- Flush 10 cycles after start → IDLE next cycle, no `done`, `result` keeps its prior value. Start and flush in the same cycle → start dropped, `ready` stays 1.
- Reset pulsed mid-CALC → ready=1, busy=0, done=0, result=0 immediately. A following MUL 3×5 returns 15 with normal latency.
